mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester/memory bus bundle for mem_arbiter
// Ports (slave = arbiter view):
//   fetch : if_req, if_addr in; if_ack, if_rdata out
//   data  : d_req, d_we, d_addr, d_wdata in; d_ack, d_rdata out
//   memory: mem_en, mem_we, mem_addr, mem_wdata out; mem_rdata in
//   status: busy, grant out
// The master modport is the other side: both requesters plus the memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              grant;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy, grant
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy, grant
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single fixed-latency memory
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (requesters, memory port, busy, grant)
// Parameters: ADDR_W, DATA_W, WAIT_CYCLES (1..15 memory cycles per transfer)
// Optional macro MEM_ARBITER_ROUND_ROBIN_EN: on a tie, the port not granted
// last wins; otherwise data always beats fetch.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    stateT             state;
    logic [3:0]        waitCnt;
    logic              grantR;
    logic              busyR;
    logic              memEn;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic              ifAck;
    logic              dAck;
    logic [DATA_W-1:0] ifRdata;
    logic [DATA_W-1:0] dRdata;
    logic              pickData;

    // grantR doubles as the last-owner register, so round-robin needs no
    // extra state: it resets to fetch, which hands the first tie to data.
    always_comb begin
        pickData = bus.d_req;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        if (bus.d_req && bus.if_req) begin
            pickData = ~grantR;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            waitCnt  <= '0;
            grantR   <= 1'b0;
            busyR    <= 1'b0;
            memEn    <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            ifAck    <= 1'b0;
            dAck     <= 1'b0;
            ifRdata  <= '0;
            dRdata   <= '0;
        end else begin
            ifAck <= 1'b0;
            dAck  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        grantR   <= pickData;
                        busyR    <= 1'b1;
                        memEn    <= 1'b1;
                        // Fetch is read-only, so its type is forced to read.
                        memWe    <= pickData & bus.d_we;
                        memAddr  <= pickData ? bus.d_addr : bus.if_addr;
                        memWdata <= pickData ? bus.d_wdata : '0;
                        waitCnt  <= CNT_LOAD;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (waitCnt == 4'd0) begin
                        memEn <= 1'b0;
                        memWe <= 1'b0;
                        state <= RESP;
                        if (grantR) begin
                            dAck <= 1'b1;
                            // memWe still holds the transfer type here.
                            if (!memWe) begin
                                dRdata <= bus.mem_rdata;
                            end
                        end else begin
                            ifAck   <= 1'b1;
                            ifRdata <= bus.mem_rdata;
                        end
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                RESP: begin
                    // Requests seen here belong to the transfer just acked.
                    busyR <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_ack    = ifAck;
    assign bus.if_rdata  = ifRdata;
    assign bus.d_ack     = dAck;
    assign bus.d_rdata   = dRdata;
    assign bus.mem_en    = memEn;
    assign bus.mem_we    = memWe;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.busy      = busyR;
    assign bus.grant     = grantR;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter (WAIT_CYCLES 2 and 1)
module tb_mem_arbiter;
    localparam int          W   = 2;
    localparam logic [31:0] KEY = 32'h8C010044;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    // Memory model: read data is a fixed function of the address.
    assign bus.mem_rdata  = bus.mem_addr ^ KEY;
    assign bus1.mem_rdata = bus1.mem_addr ^ KEY;

    typedef struct {
        logic        isData;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ackCyc;
    } txnT;

    txnT         sb[$];
    txnT         cur;
    int          passCnt = 0;
    int          totalCnt = 0;
    int          cyc = 0;
    logic [31:0] expIf = '0;
    logic [31:0] expD = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pushTxn(input logic isData, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ackCyc);
        txnT e;
        e.isData = isData;
        e.we     = we;
        e.addr   = addr;
        e.wdata  = wdata;
        e.ackCyc = ackCyc;
        if (we) begin
            e.rdata = expD;
        end else begin
            e.rdata = addr ^ KEY;
            if (isData) expD = e.rdata;
            else expIf = e.rdata;
        end
        sb.push_back(e);
    endtask

    // which: 0 = fetch ack, 1 = data ack, 2 = either
    task automatic waitAck(input int which);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if ((which != 0 && bus.d_ack) || (which != 1 && bus.if_ack)) seen = 1'b1;
        end
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: tracks each mem_en run and scores every ack against the queue.
    int          enRun = 0;
    int          weNoEn = 0;
    logic        prevEn = 1'b0;
    logic        runStable = 1'b1;
    logic        runWe = 1'b0;
    logic [31:0] runAddr = '0;
    logic [31:0] runWdata = '0;

    always @(negedge clk) begin
        if (bus.mem_we && !bus.mem_en) weNoEn++;
        if (bus.mem_en) begin
            if (!prevEn) begin
                enRun     = 1;
                runAddr   = bus.mem_addr;
                runWdata  = bus.mem_wdata;
                runWe     = bus.mem_we;
                runStable = 1'b1;
            end else begin
                enRun++;
                if (bus.mem_addr !== runAddr || bus.mem_wdata !== runWdata || bus.mem_we !== runWe)
                    runStable = 1'b0;
            end
        end
        prevEn = bus.mem_en;
        if (bus.if_ack || bus.d_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
            end else begin
                cur = sb.pop_front();
                check("ack_port", {30'd0, bus.if_ack, bus.d_ack}, cur.isData ? 32'd1 : 32'd2);
                check("grant", 32'(bus.grant), 32'(cur.isData));
                check("latency", 32'(cyc), 32'(cur.ackCyc));
                check("access_len", 32'(enRun), 32'(W));
                check("mem_stable", 32'(runStable), 32'd1);
                check("mem_addr", runAddr, cur.addr);
                check("mem_we", 32'(runWe), 32'(cur.we));
                if (cur.we) check("mem_wdata", runWdata, cur.wdata);
                if (cur.isData) check("d_rdata", bus.d_rdata, cur.rdata);
                else check("if_rdata", bus.if_rdata, cur.rdata);
                check("busy_resp", 32'(bus.busy), 32'd1);
            end
        end
    end

    int k;
    int ackAt;

    initial begin
        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0;
        bus1.if_req = 0; bus1.if_addr = '0; bus1.d_req = 0; bus1.d_we = 0;
        bus1.d_addr = '0; bus1.d_wdata = '0;
        repeat (2) @(negedge clk);

        check("rst_flags", {24'd0, bus.mem_en, bus.mem_we, bus.busy, bus.grant,
                            bus.if_ack, bus.d_ack, 2'b00}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_rdata", bus.if_rdata | bus.d_rdata, 32'd0);

        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous requests.
        k = cyc;
        bus.if_req = 1; bus.if_addr = 32'h44;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        pushTxn(1, 0, 32'h80, 32'h0, k + 1 + W);
        pushTxn(0, 0, 32'h44, 32'h0, k + 1 + W + (W + 2));
        pushTxn(1, 0, 32'h80, 32'h0, k + 1 + W + 2 * (W + 2));
        repeat (3) waitAck(2);
        bus.d_req = 0; bus.if_req = 0;
`else
        pushTxn(1, 0, 32'h80, 32'h0, k + 1 + W);
        pushTxn(0, 0, 32'h44, 32'h0, k + 1 + W + (W + 2));
        waitAck(1); bus.d_req = 0;
        waitAck(0); bus.if_req = 0;
`endif
        repeat (2) @(negedge clk);

        // Single fetch read.
        k = cyc;
        bus.if_req = 1; bus.if_addr = 32'h40;
        pushTxn(0, 0, 32'h40, 32'h0, k + 1 + W);
        waitAck(0); bus.if_req = 0;
        check("fetch_0x40_data", bus.if_rdata, 32'h8C010004);
        repeat (2) @(negedge clk);

        // Data write: d_rdata must keep the last read value.
        k = cyc;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF;
        pushTxn(1, 1, 32'h100, 32'hDEADBEEF, k + 1 + W);
        waitAck(1); bus.d_req = 0; bus.d_we = 0;
        repeat (2) @(negedge clk);

        // Request dropped during ACCESS still completes.
        k = cyc;
        bus.d_req = 1; bus.d_addr = 32'h20;
        pushTxn(1, 0, 32'h20, 32'h0, k + 1 + W);
        @(negedge clk);
        bus.d_req = 0;
        waitAck(1);
        repeat (3) @(negedge clk);
        check("idle_after_drop", 32'(bus.busy), 32'd0);

        // Reset in the middle of ACCESS.
        bus.d_req = 1; bus.d_addr = 32'h300;
        @(negedge clk);
        check("pre_rst_mem_en", 32'(bus.mem_en), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_addr", bus.mem_addr, 32'd0);
        expIf = '0; expD = '0;
        repeat (3) @(negedge clk);
        check("rst_no_ack", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
        rst_n = 1'b1;
        k = cyc;
        pushTxn(1, 0, 32'h300, 32'h0, k + 1 + W);
        waitAck(1); bus.d_req = 0;
        repeat (2) @(negedge clk);

        // WAIT_CYCLES = 1 instance, request dropped during ACCESS.
        k = cyc;
        ackAt = -1;
        bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 32'h500;
        @(negedge clk);
        check("w1_mem_en", 32'(bus1.mem_en), 32'd1);
        bus1.d_req = 0;
        for (int i = 0; i < 10 && ackAt < 0; i++) begin
            if (bus1.d_ack) ackAt = cyc;
            else @(negedge clk);
        end
        check("w1_latency", 32'(ackAt), 32'(k + 2));
        check("w1_rdata", bus1.d_rdata, 32'h500 ^ KEY);
        @(negedge clk);
        check("w1_ack_pulse", 32'(bus1.d_ack), 32'd0);
        @(negedge clk);
        check("w1_idle", {30'd0, bus1.busy, bus1.mem_en}, 32'd0);

        check("we_without_en", 32'(weNoEn), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
